seq_detect_ctrl: RTL

- Programmable serial pattern-detector controller: a generalised, run-time configurable version of the fixed Mealy sequence detectors (e.g. 0101).
- Holds the pattern configuration (bits, length, overlap mode, match limit).
- Sequences a detection run through IDLE/RUN/DONE states, counts matches, and gives a Mealy match pulse on the serial stream.
- Sits between a host config/control interface and a qualified serial bit stream.

---
 rtl/seq_detect_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl
// Programmable serial pattern-detector controller. Holds a run-time pattern
// configuration, sequences detection runs through IDLE/RUN/DONE, counts
// matches and gives a Mealy match pulse on a qualified serial stream.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   cfg_we              config write strobe (accepted in IDLE/DONE, legal len only)
//   cfg_pattern         pattern; bit [len-1] is received first, bit [0] last
//   cfg_len             pattern length, legal 2..PW
//   cfg_overlap         1 = overlapping detection, 0 = restart after a match
//   cfg_max             match limit, 0 = unlimited
//   start, abort        run control; abort wins when both are high
//   x, x_valid          serial data bit and its qualifier
//   y                   Mealy match pulse (combinational, RUN only)
//   busy, done          high in RUN / DONE
//   match_count         matches in the current or last run (saturating)
//   cfg_err             one-cycle pulse after a rejected config write
//
// Handshake: a serial bit is consumed on a rising edge where x_valid is high
// and the FSM is in RUN; y is valid in the same cycle as that bit.
module seq_detect_ctrl #(
    parameter int PW = 8,
    parameter int CW = 8,
    parameter int LW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_we,
    input  logic [PW-1:0] cfg_pattern,
    input  logic [LW-1:0] cfg_len,
    input  logic          cfg_overlap,
    input  logic [CW-1:0] cfg_max,
    input  logic          start,
    input  logic          abort,
    input  logic          x,
    input  logic          x_valid,
    output logic          y,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] match_count,
    output logic          cfg_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [PW-1:0] RST_PAT = PW'(5);
    localparam logic [LW-1:0] RST_LEN = LW'(4);

    state_t        state_q, state_d;
    logic [PW-1:0] pat_q, pat_d;
    logic [LW-1:0] len_q, len_d;
    logic          ovl_q, ovl_d;
    logic [CW-1:0] max_q, max_d;
    logic [PW-2:0] hist_q, hist_d;
    logic [LW-1:0] fill_q, fill_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    logic [PW-1:0] cand;
    logic [PW-1:0] mask;
    logic          match;
    logic          fill_ok;
    logic          bit_ev;
    logic          cfg_ok;
    logic [CW-1:0] cnt_inc;
    logic [LW-1:0] fill_inc;

    always_comb begin
        // Candidate word: newest bit in position 0, older history above it.
        cand = {hist_q, x};
        mask = '0;
        for (int i = 0; i < PW; i++) begin
            mask[i] = (i < int'(len_q));
        end
        match    = ((cand ^ pat_q) & mask) == '0;
        fill_ok  = fill_q >= (len_q - LW'(1));
        bit_ev   = (state_q == ST_RUN) && x_valid;
        y        = bit_ev && match && fill_ok;
        cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
        fill_inc = (fill_q >= LW'(PW)) ? fill_q : fill_q + LW'(1);
        cfg_ok   = cfg_we && (state_q != ST_RUN) &&
                   (cfg_len >= LW'(2)) && (cfg_len <= LW'(PW));

        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        max_d   = max_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;
        err_d   = cfg_we && !cfg_ok;

        if (cfg_ok) begin
            pat_d = cfg_pattern;
            len_d = cfg_len;
            ovl_d = cfg_overlap;
            max_d = cfg_max;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    hist_d  = '0;
                    fill_d  = '0;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (bit_ev) begin
                    if (y) begin
                        cnt_d = cnt_inc;
                        if (ovl_q) begin
                            hist_d = cand[PW-2:0];
                            fill_d = fill_inc;
                        end else begin
                            // Non-overlapping: the matched bits cannot start a new match.
                            hist_d = '0;
                            fill_d = '0;
                        end
                        if ((max_q != '0) && (cnt_inc == max_q)) begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        hist_d = cand[PW-2:0];
                        fill_d = fill_inc;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pat_q   <= RST_PAT;
            len_q   <= RST_LEN;
            ovl_q   <= 1'b0;
            max_q   <= '0;
            hist_q  <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            max_q   <= max_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign busy        = (state_q == ST_RUN);
    assign done        = (state_q == ST_DONE);
    assign match_count = cnt_q;
    assign cfg_err     = err_q;

endmodule
